hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Scoreboard controller that sequences the Decode stage of the 6-stage RV32I pipeline (decode = Ps2, execute = Ps4, register-file write-back = Ps6).
- Tracks, per architectural register, how many cycles remain until its in-flight result reaches the register file.
- Asserts a stall that holds Decode while a source register is pending, and gates instruction issue on stall and flush.
- Because the register file bypasses a same-cycle write to the read port, a register is readable in its write-back cycle.

Parameters:
- NUM_REGS, 32, architectural integer registers; x0 is never tracked.
- REG_ADDR_W, 5, register address width.
- WB_DIST, 4, cycles from decode issue to the write-back cycle.
- KILL_THRESH, 2, on flush, counters above this value belong to squashed instructions.
- CNT_W, 3, counter width; must hold WB_DIST.
- PERF_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  Decode holds a valid instruction
- dec_rs1  in  REG_ADDR_W  source 1 address
- dec_rs2  in  REG_ADDR_W  source 2 address
- dec_use_rs1  in  1  instruction reads rs1
- dec_use_rs2  in  1  instruction reads rs2 (low for I-type)
- dec_rd  in  REG_ADDR_W  destination address
- dec_wr_rd  in  1  instruction writes rd
- flush  in  1  branch/jump redirect resolved in Ps4
- stall  out  1  hold Fetch/Decode registers, inject bubble into Ps3
- issue  out  1  instruction leaves Decode this cycle
- busy_vec  out  NUM_REGS  per-register pending bit (bit 0 always 0)
- stall_cycles  out  PERF_W  count of cycles with stall=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - All counters clear to 0 and stall_cycles clears to 0.
  - Consequently stall=0, issue=dec_valid, and busy_vec=0 from the next cycle.
  - Reset asserted mid-operation discards all pending state; there is no draining.
- Counter semantics: cnt[r] = cycles until r's write-back cycle, so 0 means not pending. busy_vec[r] = (cnt[r] != 0).
- Stall (combinational) = dec_valid && !flush && ((dec_use_rs1 && dec_rs1 != 0 && cnt[dec_rs1] != 0) || (dec_use_rs2 && dec_rs2 != 0 && cnt[dec_rs2] != 0)).
- Issue (combinational) = dec_valid && !stall && !flush.
- Per-register update each clk edge, r = 1..31, priority highest first:
  1. flush && cnt[r] > KILL_THRESH → 0 (younger instruction squashed).
  2. issue && dec_wr_rd && dec_rd == r → WB_DIST-1.
  3. cnt[r] != 0 → cnt[r]-1.
  4. Otherwise hold.
- flush forces issue=0, so rules 1 and 2 never collide.
- Register x0 is hard-wired to 0; writes to it are ignored.
- WAW: a re-issue to a pending rd overwrites its counter with WB_DIST-1, which is always ≥ the old value.
- RAW on the same instruction (rd == rs1): the stall check uses the current counters before the update, so the instruction is not self-stalled.
- Back-to-back dependent pair with WB_DIST=4 → 3 stall cycles; the consumer issues in the producer's write-back cycle.
- Counters never wrap: decrement is applied only when nonzero.
- stall_cycles increments when stall=1 and saturates at all-ones.
- Issue latency: 0 cycles, combinational from Decode inputs. Scoreboard state latency: 1 cycle.

Decomposition:
- instructions_pkg additions:
  - Constants: NUM_REGS, REG_ADDR_W, WB_DIST, KILL_THRESH, CNT_W.
  - Typedef sb_cnt_t = logic [CNT_W-1:0].
  - Typedef reg_addr_t = logic [REG_ADDR_W-1:0].
- Sub-module sb_entry: one per-register countdown implementing the priority update (inputs set, kill, rst; output cnt). Instantiated by a generate loop for r = 1..NUM_REGS-1.
- Top level holds the stall/issue logic, the decoders and the perf counter.

Test Plan:
- Reset mid-flight: issue write to x5, assert rst the next cycle → busy_vec=0 after the edge; a dependent read of x5 stalls 0 cycles.
- RAW: issue add x5 (wr), then a consumer with dec_use_rs1 and rs1=5 → stall=1 for 3 cycles, issue on the 4th cycle; stall_cycles=3.
- I-type immunity: producer x7, then consumer with rs2=7 and dec_use_rs2=0 → no stall.
- x0: producer writes x0, consumer reads x0 → busy_vec[0]=0, no stall.
- Flush: issue wr x3 at t, wr x4 at t+1, flush at t+2 → cnt[x3]=2 is kept, cnt[x4]=3 is cleared, issue=0 at t+2; a reader of x4 at t+3 does not stall.
- WAW + saturation: issue wr x9 twice, 1 cycle apart → busy_vec[9] stays high until 4 cycles after the second issue. Force stall_cycles to all-ones via a long stall → it holds all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and types for the decode hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int NUM_REGS    = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int WB_DIST     = 4;
    localparam int KILL_THRESH = 2;
    localparam int CNT_W       = 3;

    typedef logic [CNT_W-1:0]      sb_cnt_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// rtl/hazard_scoreboard_entry.sv - per-register countdown to write-back
module sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    set,
    input  logic    kill,
    output sb_cnt_t cnt
);

    // A flush only squashes results younger than the redirecting branch,
    // i.e. those still far from write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (kill && (cnt > sb_cnt_t'(KILL_THRESH))) begin
            cnt <= '0;
        end else if (set) begin
            cnt <= sb_cnt_t'(WB_DIST - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - sb_cnt_t'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage RAW stall and issue control with per-register scoreboard
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int PERF_W = 32
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  reg_addr_t           dec_rs1,
    input  reg_addr_t           dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  reg_addr_t           dec_rd,
    input  logic                dec_wr_rd,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PERF_W-1:0]   stall_cycles
);

    sb_cnt_t                 cnt [NUM_REGS];
    logic [NUM_REGS-1:1]     set_vec;
    logic                    rs1_pend;
    logic                    rs2_pend;

    assign cnt[0] = '0;

    // Counters are read before this cycle's update, so rd == rs1 never self-stalls.
    assign rs1_pend = dec_use_rs1 && (dec_rs1 != '0) && (cnt[dec_rs1] != '0);
    assign rs2_pend = dec_use_rs2 && (dec_rs2 != '0) && (cnt[dec_rs2] != '0);
    assign stall    = dec_valid && !flush && (rs1_pend || rs2_pend);
    assign issue    = dec_valid && !stall && !flush;

    always_comb begin
        set_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            set_vec[r] = issue && dec_wr_rd && (dec_rd == reg_addr_t'(r));
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry u_entry (
            .clk  (clk),
            .rst  (rst),
            .set  (set_vec[r]),
            .kill (flush),
            .cnt  (cnt[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard-style bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic [4:0]  dec_rd;
    logic        dec_wr_rd;
    logic        flush;
    logic        stall;
    logic        issue;
    logic [31:0] busy_vec;
    logic [PW-1:0] stall_cycles;

    typedef struct {
        int          idx;
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        int          perf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.PERF_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_use_rs1  (dec_use_rs1),
        .dec_use_rs2  (dec_use_rs2),
        .dec_rd       (dec_rd),
        .dec_wr_rd    (dec_wr_rd),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    task automatic step(input logic r, input logic v, input int rs1, input logic u1,
                        input int rs2, input logic u2, input int rd, input logic wr,
                        input logic fl, input logic es, input logic ei,
                        input logic [31:0] eb, input int ep);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        dec_valid   = v;
        dec_rs1     = 5'(rs1);
        dec_use_rs1 = u1;
        dec_rs2     = 5'(rs2);
        dec_use_rs2 = u2;
        dec_rd      = 5'(rd);
        dec_wr_rd   = wr;
        flush       = fl;
        e.idx   = vec_n;
        e.stall = es;
        e.issue = ei;
        e.busy  = eb;
        e.perf  = ep;
        exp_q.push_back(e);
        vec_n++;
    endtask

    task automatic idle(input logic [31:0] eb, input int ep);
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, eb, ep);
    endtask

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (stall !== e.stall) begin
                    errors++;
                    $display("FAIL stall vec %0d: got %b expected %b", e.idx, stall, e.stall);
                end
                checks++;
                if (issue !== e.issue) begin
                    errors++;
                    $display("FAIL issue vec %0d: got %b expected %b", e.idx, issue, e.issue);
                end
                checks++;
                if (busy_vec !== e.busy) begin
                    errors++;
                    $display("FAIL busy_vec vec %0d: got %h expected %h", e.idx, busy_vec, e.busy);
                end
                checks++;
                if (stall_cycles !== PW'(e.perf)) begin
                    errors++;
                    $display("FAIL stall_cycles vec %0d: got %0d expected %0d", e.idx, stall_cycles, e.perf);
                end
            end
        end
    end

    initial begin
        int p;
        int waited;
        rst = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
        dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_rd = '0; dec_wr_rd = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // Reset state, then reset mid-flight discards pending x5
        idle(32'h0, 0);
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 32'h0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);

        // RAW on x5: three stall cycles, issue in write-back cycle
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 32'h0, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 1);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 2);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 3);

        // I-type ignores rs2
        step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 32'h0, 3);
        step(0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 1, 32'h80, 3);
        idle(32'h80, 3);
        idle(32'h80, 3);
        idle(32'h0, 3);

        // x0 never tracked
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 3);
        step(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 32'h0, 3);

        // Flush keeps x3 (cnt 2), kills x4 (cnt 3), masks stall and issue
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 32'h0, 3);
        step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 32'h8, 3);
        step(0, 1, 3, 1, 0, 0, 10, 1, 1, 0, 0, 32'h18, 3);
        step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 3);
        idle(32'h0, 3);

        // WAW on x9: busy until 4 cycles after the second issue
        step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 32'h0, 3);
        idle(32'h200, 3);
        step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 32'h200, 3);
        idle(32'h200, 3);
        idle(32'h200, 3);
        idle(32'h200, 3);
        idle(32'h0, 3);

        // rd == rs1 does not self-stall; the next reader does
        step(0, 1, 11, 1, 0, 0, 11, 1, 0, 0, 1, 32'h0, 3);
        step(0, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 32'h800, 3);
        step(0, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 32'h800, 4);
        step(0, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 32'h800, 5);
        step(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 6);

        // Drive stall_cycles into saturation with repeated dependent pairs on x12
        p = 6;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 32'h0, p);
            for (int s = 0; s < 3; s++) begin
                step(0, 1, 12, 1, 0, 0, 0, 0, 0, 1, 0, 32'h1000, sat(p + s));
            end
            p = sat(p + 3);
            step(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, p);
        end
        idle(32'h0, 15);

        // Reset clears the perf counter
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 15);
        idle(32'h0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
